// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// FSM states and op-class helpers.
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Every op below MTHI is multi-cycle; codes above MTLO are NOPs.
  function automatic logic is_multi(input logic [3:0] op);
    return op <= OP_MSUBU;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational multiply/divide/accumulate evaluator. It sees the latched
// operands and the live HI/LO, and returns the new HI/LO plus a write enable.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_valid
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn, a_neg, b_neg;
  logic [W2-1:0]    a_ext, b_ext, prod, acc;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign sgn   = is_signed_op(op);
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_ext = {{WIDTH{a_neg}}, a};
  assign b_ext = {{WIDTH{b_neg}}, b};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi, lo};

  // Sign-magnitude division: MIN / -1 naturally wraps to MIN with remainder 0.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    {res_hi, res_lo} = acc;
    res_valid        = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        {res_hi, res_lo} = prod;
        res_valid        = 1'b1;
      end
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = acc + prod;
        res_valid        = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = acc - prod;
        res_valid        = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi    = rem;
        res_lo    = quo;
        res_valid = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_muldiv.sv
// HI/LO multiply/divide unit: issue FSM, latency counter and the
// architectural HI/LO registers around a combinational evaluator.
module pipe_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept, complete;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Cancel beats completion, so a kill in the last busy cycle drops the result.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          accept = 1'b1;
          if (is_multi(op)) begin
            state_nxt = RUN;
            cnt_nxt   = is_div_class(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          complete  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == RUN);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi       (hi),
    .lo       (lo),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .res_valid(res_valid)
  );

  // MTHI/MTLO write straight from the port; multi-cycle ops write on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      done <= complete;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        if (op == OP_MTHI) hi <= a;
        if (op == OP_MTLO) lo <= a;
      end
      if (complete && res_valid) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: doc/pipe_muldiv.md
PIPE_MULDIV -- requirements
Module: pipe_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width and the width of each of HI and LO.
REQ-002 SHALL have parameter MUL_LAT, default 5, the busy cycles for mult-class ops; legal range is >=1.
REQ-003 SHALL have parameter DIV_LAT, default 10, the busy cycles for div-class ops; legal range is >=1.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start  in  1  a one-cycle request to issue op.
REQ-007 SHALL have port op  in  4  the operation code, using the package encoding.
REQ-008 SHALL have port a  in  WIDTH  operand rs.
REQ-009 SHALL have port b  in  WIDTH  operand rt.
REQ-010 SHALL have port cancel  in  1  the exception/interrupt kill; it aborts the in-flight op and blocks a same-cycle start.
REQ-011 SHALL have port busy  out  1  high while an op is in flight.
REQ-012 SHALL have port done  out  1  a one-cycle pulse on the cycle new HI/LO from a multi-cycle op first become visible.
REQ-013 SHALL have port hi  out  WIDTH  the architectural HI register.
REQ-014 SHALL have port lo  out  WIDTH  the architectural LO register.

Function
REQ-015 SHALL support these ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO; any other code is a NOP.
REQ-016 SHALL implement a two-state FSM with states IDLE and RUN, plus a latency counter of width $clog2(max(MUL_LAT,DIV_LAT)+1).
REQ-017 SHALL accept a start only when all of the following hold: state is IDLE, cancel=0 and start=1; an accepted start latches op, a and b.
REQ-018 SHALL ignore start while busy, and SHALL NOT queue it.
REQ-019 SHALL, for MTHI/MTLO accepted in cycle T, write a to hi/lo at the end of cycle T, with no busy and no done.
REQ-020 SHALL, for a multi-cycle op accepted in cycle T, hold busy=1 in cycles T+1..T+LAT, where LAT is MUL_LAT for the mult class and DIV_LAT for the div class.
REQ-021 SHALL make the multi-cycle result visible on hi/lo in cycle T+LAT+1, with done=1 and busy=0 in that same cycle.
REQ-022 SHALL accept a new start in the done cycle, which gives back-to-back issue.
REQ-023 SHALL compute the result only from the latched operands; changes on a and b after acceptance have no effect.
REQ-024 MULT/MULTU SHALL produce the signed/unsigned 2*WIDTH product P, with {hi,lo}=P.
REQ-025 MADD(U)/MSUB(U) SHALL compute {hi,lo} = {hi,lo} ± P modulo 2^(2*WIDTH), using the hi/lo values at completion time.
REQ-026 DIV SHALL give lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend; DIVU SHALL do the same unsigned.
REQ-027 SHALL, for divide by zero, still take DIV_LAT cycles and pulse done, while leaving hi/lo unchanged.
REQ-028 SHALL, for signed DIV of the most negative value by -1, give lo = most negative value and hi = 0.
REQ-029 SHALL, on cancel=1 during RUN, return to IDLE the next cycle with hi/lo unchanged and no done.
REQ-030 SHALL, when cancel=1 in the would-be completion cycle T+LAT, suppress the result; cancel takes priority over completion.
REQ-031 SHALL treat cancel in IDLE with no start as a no-op.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0 and lo=0, independent of clk and including mid-operation.
REQ-033 SHALL, on the first edge after reset deasserts, behave as IDLE.

Structure
REQ-034 SHALL place the op encoding constants and the FSM state constants in a shared package, muldiv_pkg, used by the control unit and the datapath.
REQ-035 SHALL use one sub-module, muldiv_core, a combinational WIDTH-parametrised multiply/divide/accumulate evaluator; the FSM, counter and HI/LO registers stay in pipe_muldiv.
REQ-036 SHALL hold HI/LO architectural state only in pipe_muldiv, with no shadow copies visible to the datapath.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-037 SHALL cover: MULT a=0xFFFFFFFD b=7 at T -> busy for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFEB and done=1 for one cycle.
REQ-038 SHALL cover: DIVU 100/7 -> lo=14, hi=2 after 10 busy cycles; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV x/0 -> hi/lo unchanged and done pulses.
REQ-039 SHALL cover: MULT started with hi=lo=0x11, cancel=1 in the 3rd busy cycle -> busy=0 next cycle, hi=lo=0x11, done never asserts; also cancel at T+5 -> no update.
REQ-040 SHALL cover: start of MTHI 0x5 while busy -> ignored, hi unaffected; a start with cancel=1 in IDLE -> ignored; MTLO 0x9 in IDLE -> lo=0x9 next cycle, busy stays 0.
REQ-041 SHALL cover: MTHI 0, MTLO 0xFFFFFFFF, then MADD 1*1 -> hi=1, lo=0; then MSUBU 1*1 -> hi=0, lo=0xFFFFFFFF.
REQ-042 SHALL cover: reset driven low mid-DIV with no clk edge -> busy=0, hi=0, lo=0 immediately; after release an MTLO is accepted normally.
